// File: rtl/alarm_select_ctrl_pkg.sv
// Shared definitions for the alarm-select PIO controller: PIO register map,
// controller state encoding, zone type and the per-state bus drive values.
package alarm_ctrl_pkg;

    // PIO register addresses
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE     = 2'd3;

    // Zone index as seen on the select pins
    typedef logic [3:0] zone_t;

    // Controller states, kept as plain constants so the encoding is fixed
    typedef logic [3:0] state_t;
    localparam state_t ST_INIT      = 4'd0;
    localparam state_t ST_INIT_MASK = 4'd1;
    localparam state_t ST_INIT_CLR  = 4'd2;
    localparam state_t ST_IDLE      = 4'd3;
    localparam state_t ST_RD_EDGE   = 4'd4;
    localparam state_t ST_RD_EDGE_W = 4'd5;
    localparam state_t ST_CLR       = 4'd6;
    localparam state_t ST_RD_DATA   = 4'd7;
    localparam state_t ST_DEBOUNCE  = 4'd8;
    localparam state_t ST_PUBLISH   = 4'd9;

    // One cycle of Avalon-MM master drive
    typedef struct packed {
        logic [1:0]  address;
        logic        chipselect;
        logic        write_n;
        logic [31:0] writedata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{address: 2'd0, chipselect: 1'b0,
                                  write_n: 1'b1, writedata: 32'd0};

    // Bus drive for the cycle spent in state s; edges is the value to clear in CLR
    function automatic bus_t bus_for_state(input state_t s, input zone_t edges);
        bus_t b;
        b = BUS_IDLE;
        case (s)
            ST_INIT_MASK: begin
                b.address    = ADDR_IRQ_MASK;
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.writedata  = 32'h0000_000F;
            end
            ST_INIT_CLR: begin
                b.address    = ADDR_EDGE;
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.writedata  = 32'h0000_000F;
            end
            ST_RD_EDGE, ST_RD_EDGE_W: begin
                b.address = ADDR_EDGE;
            end
            ST_CLR: begin
                b.address    = ADDR_EDGE;
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.writedata  = {28'd0, edges};
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/alarm_select_ctrl_if.sv
// Bundle of the PIO Avalon-MM master bus and the zone valid/ready output.
interface alarm_select_ctrl_if;
    import alarm_ctrl_pkg::*;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    zone_t       zone_sel;
    logic        zone_valid;
    logic        zone_ready;
    logic [7:0]  change_cnt;

    // Controller side
    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata,
        output zone_sel, zone_valid, change_cnt,
        input  zone_ready
    );

    // PIO / consumer side
    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata,
        input  zone_sel, zone_valid, change_cnt,
        output zone_ready
    );

endinterface

// File: rtl/alarm_select_ctrl.sv
// Autonomous service controller for the 4-bit alarm-select PIO: arms the
// PIO, handles its edge interrupt, debounces the pins and publishes zone
// changes over valid/ready. Bus outputs are registered from the next state
// so each state's drive is visible while that state is current.
module alarm_select_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 irq,
    alarm_select_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

    state_t           state, state_next;
    bus_t             drv;
    zone_t            sample;
    zone_t            cand, cand_next;
    zone_t            zone_sel, zone_sel_next;
    logic [CNT_W-1:0] count, count_next, count_inc;
    logic             zone_valid, zone_valid_next;
    logic [7:0]       change_cnt, change_cnt_next;
    logic             unused_rdata;

    // Only the low nibble of the PIO carries pin / edge information
    assign sample       = bus.avm_readdata[3:0];
    assign unused_rdata = ^bus.avm_readdata[31:4];
    assign count_inc    = count + CNT_W'(1);

    assign bus.avm_address    = drv.address;
    assign bus.avm_chipselect = drv.chipselect;
    assign bus.avm_write_n    = drv.write_n;
    assign bus.avm_writedata  = drv.writedata;
    assign bus.zone_sel       = zone_sel;
    assign bus.zone_valid     = zone_valid;
    assign bus.change_cnt     = change_cnt;

    // Next-state, debounce and publish decisions
    always_comb begin
        state_next      = state;
        cand_next       = cand;
        count_next      = count;
        zone_sel_next   = zone_sel;
        zone_valid_next = zone_valid;
        change_cnt_next = change_cnt;
        case (state)
            ST_INIT:      state_next = ST_INIT_MASK;
            ST_INIT_MASK: state_next = ST_INIT_CLR;
            ST_INIT_CLR:  state_next = ST_IDLE;
            ST_IDLE: begin
                if (irq && enable) state_next = ST_RD_EDGE;
            end
            ST_RD_EDGE:   state_next = ST_RD_EDGE_W;
            ST_RD_EDGE_W: begin
                // A spurious interrupt with nothing captured needs no clear
                state_next = (sample == 4'd0) ? ST_IDLE : ST_CLR;
            end
            ST_CLR:       state_next = ST_RD_DATA;
            ST_RD_DATA: begin
                count_next = '0;
                state_next = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (count == '0 || sample != cand) begin
                    cand_next  = sample;
                    count_next = CNT_W'(1);
                end else begin
                    count_next = count_inc;
                    if (count_inc == STABLE_N) begin
                        if (cand != zone_sel) begin
                            zone_sel_next   = cand;
                            zone_valid_next = 1'b1;
                            state_next      = ST_PUBLISH;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_PUBLISH: begin
                // Stay here (zone_sel and cand frozen) until the consumer takes it
                if (bus.zone_ready) begin
                    change_cnt_next = change_cnt + 8'd1;
                    zone_valid_next = 1'b0;
                    state_next      = ST_IDLE;
                end
            end
            default:      state_next = ST_INIT;
        endcase
    end

    // State, bus drive and zone registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            drv        <= BUS_IDLE;
            cand       <= '0;
            count      <= '0;
            zone_sel   <= '0;
            zone_valid <= 1'b0;
            change_cnt <= '0;
        end else begin
            state      <= state_next;
            drv        <= bus_for_state(state_next, sample);
            cand       <= cand_next;
            count      <= count_next;
            zone_sel   <= zone_sel_next;
            zone_valid <= zone_valid_next;
            change_cnt <= change_cnt_next;
        end
    end

endmodule

// File: tb/tb_alarm_select_ctrl.sv
// Bench for alarm_select_ctrl with a behavioural PIO (data / irq mask /
// edge capture) and a scoreboard of expected zone publications.
module tb_alarm_select_ctrl;
    import alarm_ctrl_pkg::*;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b1;
    logic irq;

    alarm_select_ctrl_if bus_if ();

    alarm_select_ctrl #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .irq     (irq),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- PIO model ----------------
    logic [3:0]  pins    = 4'd0;
    logic [3:0]  pins_q  = 4'd0;
    logic [3:0]  mask_r  = 4'd0;
    logic [3:0]  edge_r  = 4'd0;
    logic [3:0]  edge_nx;
    logic [31:0] rdata   = 32'd0;
    logic        wr_en;

    assign wr_en = bus_if.avm_chipselect && !bus_if.avm_write_n;
    assign irq   = |(edge_r & mask_r);
    assign bus_if.avm_readdata = rdata;

    always_comb begin
        edge_nx = edge_r;
        if (wr_en && bus_if.avm_address == 2'd3) edge_nx = edge_nx & ~bus_if.avm_writedata[3:0];
        edge_nx = edge_nx | (pins ^ pins_q);
    end

    always @(posedge clk) begin
        pins_q <= pins;
        edge_r <= edge_nx;
        if (wr_en && bus_if.avm_address == 2'd2) mask_r <= bus_if.avm_writedata[3:0];
        case (bus_if.avm_address)
            2'd0:    rdata <= {28'd0, pins};
            2'd2:    rdata <= {28'd0, mask_r};
            2'd3:    rdata <= {28'd0, edge_r};
            default: rdata <= 32'd0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    typedef struct { logic [1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [3:0] zone; logic [7:0] cnt; } pub_t;

    wr_t        wr_q[$];
    pub_t       exp_q[$];
    int         pub_count   = 0;
    logic [7:0] model_cnt   = 8'd0;
    logic       cnt_pending = 1'b0;
    logic [7:0] cnt_want    = 8'd0;

    function automatic void push_exp(input logic [3:0] z);
        model_cnt = model_cnt + 8'd1;
        exp_q.push_back('{zone: z, cnt: model_cnt});
    endfunction

    always @(negedge clk) begin
        pub_t e;
        if (cnt_pending) begin
            checks++;
            if (bus_if.change_cnt !== cnt_want) begin
                errors++;
                $display("FAIL sb_change_cnt got %0d want %0d", bus_if.change_cnt, cnt_want);
            end
            cnt_pending = 1'b0;
        end
        if (wr_en) wr_q.push_back('{addr: bus_if.avm_address, data: bus_if.avm_writedata});
        if (bus_if.zone_valid && bus_if.zone_ready) begin
            pub_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_publish got zone %0d want none", bus_if.zone_sel);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.zone_sel !== e.zone) begin
                    errors++;
                    $display("FAIL sb_zone_sel got %0d want %0d", bus_if.zone_sel, e.zone);
                end else begin
                    $display("publish zone %0d (expected cnt %0d)", e.zone, e.cnt);
                end
                cnt_want    = e.cnt;
                cnt_pending = 1'b1;
            end
        end
    end

    task automatic wait_pub(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pub_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_if.avm_address !== 2'd0) begin errors++; $display("FAIL rst_address got %0d want 0", bus_if.avm_address); end
        checks++; if (bus_if.avm_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", bus_if.avm_chipselect); end
        checks++; if (bus_if.avm_write_n !== 1'b1) begin errors++; $display("FAIL rst_write_n got %b want 1", bus_if.avm_write_n); end
        checks++; if (bus_if.avm_writedata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus_if.avm_writedata); end
        checks++; if (bus_if.zone_sel !== 4'd0) begin errors++; $display("FAIL rst_zone_sel got %0d want 0", bus_if.zone_sel); end
        checks++; if (bus_if.zone_valid !== 1'b0) begin errors++; $display("FAIL rst_zone_valid got %b want 0", bus_if.zone_valid); end
        checks++; if (bus_if.change_cnt !== 8'd0) begin errors++; $display("FAIL rst_change_cnt got %0d want 0", bus_if.change_cnt); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (!(wr_en && bus_if.avm_address == 2'd2 && bus_if.avm_writedata == 32'hF)) begin
            errors++; $display("FAIL init_mask got cs=%b wn=%b a=%0d d=%h want write 2/F",
                bus_if.avm_chipselect, bus_if.avm_write_n, bus_if.avm_address, bus_if.avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (!(wr_en && bus_if.avm_address == 2'd3 && bus_if.avm_writedata == 32'hF)) begin
            errors++; $display("FAIL init_clr got cs=%b wn=%b a=%0d d=%h want write 3/F",
                bus_if.avm_chipselect, bus_if.avm_write_n, bus_if.avm_address, bus_if.avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (bus_if.avm_chipselect !== 1'b0 || bus_if.avm_address !== 2'd0) begin
            errors++; $display("FAIL init_idle got cs=%b a=%0d want cs=0 a=0", bus_if.avm_chipselect, bus_if.avm_address);
        end
        $display("reset/init sequence done");
    endtask

    task automatic test_publish_clean();
        int first_k = -1;
        int vcount  = 0;
        bit seen    = 1'b0;
        wr_q.delete();
        push_exp(4'd5);
        pins = 4'd5;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (irq) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL clean_irq got 0 want 1"); end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_if.zone_valid) begin
                vcount++;
                if (first_k < 0) first_k = k;
            end
        end
        checks++; if (first_k != 5 + STABLE) begin errors++; $display("FAIL clean_latency got %0d want %0d", first_k, 5 + STABLE); end
        checks++; if (vcount != 1) begin errors++; $display("FAIL clean_valid_len got %0d want 1", vcount); end
        checks++;
        if (wr_q.size() != 1 || wr_q[0].addr != 2'd3 || wr_q[0].data != 32'h5) begin
            errors++; $display("FAIL clean_clr_write got n=%0d a=%0d d=%h want 1 write 3/5",
                wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : 2'd0, (wr_q.size() > 0) ? wr_q[0].data : 32'd0);
        end
        checks++; if (bus_if.zone_sel !== 4'd5) begin errors++; $display("FAIL clean_zone_sel got %0d want 5", bus_if.zone_sel); end
        checks++; if (bus_if.change_cnt !== 8'd1) begin errors++; $display("FAIL clean_change_cnt got %0d want 1", bus_if.change_cnt); end
        $display("clean publish: latency %0d, valid cycles %0d", first_k, vcount);
    endtask

    task automatic test_bounce();
        int start = pub_count;
        int clr_writes = 0;
        wr_q.delete();
        push_exp(4'd7);
        pins = 4'd7; repeat (2) @(negedge clk);
        pins = 4'd5; repeat (2) @(negedge clk);
        pins = 4'd7; repeat (2) @(negedge clk);
        pins = 4'd5; repeat (2) @(negedge clk);
        pins = 4'd7; repeat (80) @(negedge clk);
        foreach (wr_q[i]) if (wr_q[i].addr == 2'd3) clr_writes++;
        checks++; if (pub_count - start != 1) begin errors++; $display("FAIL bounce_pubs got %0d want 1", pub_count - start); end
        checks++; if (clr_writes < 2) begin errors++; $display("FAIL bounce_second_pass got %0d clears want >=2", clr_writes); end
        checks++; if (bus_if.zone_sel !== 4'd7) begin errors++; $display("FAIL bounce_zone_sel got %0d want 7", bus_if.zone_sel); end
        $display("bounce: %0d publish, %0d edge clears", pub_count - start, clr_writes);
    endtask

    task automatic test_ready_low();
        int start = pub_count;
        bit seen  = 1'b0;
        bit ok;
        bus_if.zone_ready = 1'b0;
        push_exp(4'd3);
        pins = 4'd3;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.zone_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL hold_valid_rise got 0 want 1"); end
        for (int c = 0; c < 20; c++) begin
            if (c == 2) pins = 4'd9;
            @(negedge clk);
            checks++;
            if (bus_if.zone_valid !== 1'b1 || bus_if.zone_sel !== 4'd3) begin
                errors++; $display("FAIL hold_cycle%0d got v=%b z=%0d want v=1 z=3", c, bus_if.zone_valid, bus_if.zone_sel);
            end
        end
        push_exp(4'd9);
        bus_if.zone_ready = 1'b1;
        wait_pub(start + 2, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_followup got %0d pubs want 2", pub_count - start); end
        repeat (40) @(negedge clk);
        checks++; if (bus_if.zone_sel !== 4'd9) begin errors++; $display("FAIL hold_zone_sel got %0d want 9", bus_if.zone_sel); end
        $display("ready-low hold: %0d publishes after release", pub_count - start);
    endtask

    task automatic test_return_same();
        int start  = pub_count;
        int vcount = 0;
        pins = 4'd8;
        repeat (7) @(negedge clk);
        pins = 4'd9;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_if.zone_valid) vcount++;
        end
        checks++; if (vcount != 0) begin errors++; $display("FAIL same_valid got %0d cycles want 0", vcount); end
        checks++; if (bus_if.change_cnt !== model_cnt) begin errors++; $display("FAIL same_change_cnt got %0d want %0d", bus_if.change_cnt, model_cnt); end
        checks++; if (pub_count != start) begin errors++; $display("FAIL same_pubs got %0d want 0", pub_count - start); end
        $display("return-to-same: no publish");
    endtask

    task automatic test_reset_debounce();
        bit seen = 1'b0;
        pins = 4'd2;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (irq) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstdb_irq got 0 want 1"); end
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        model_cnt = 8'd0;
        @(negedge clk);
        checks++;
        if (bus_if.avm_address !== 2'd0 || bus_if.avm_chipselect !== 1'b0 || bus_if.avm_write_n !== 1'b1 ||
            bus_if.avm_writedata !== 32'd0) begin
            errors++; $display("FAIL rstdb_bus got a=%0d cs=%b wn=%b d=%h want 0/0/1/0", bus_if.avm_address,
                bus_if.avm_chipselect, bus_if.avm_write_n, bus_if.avm_writedata);
        end
        checks++;
        if (bus_if.zone_sel !== 4'd0 || bus_if.zone_valid !== 1'b0 || bus_if.change_cnt !== 8'd0) begin
            errors++; $display("FAIL rstdb_zone got z=%0d v=%b c=%0d want 0/0/0", bus_if.zone_sel,
                bus_if.zone_valid, bus_if.change_cnt);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (!(wr_en && bus_if.avm_address == 2'd2 && bus_if.avm_writedata == 32'hF)) begin
            errors++; $display("FAIL rstdb_mask got cs=%b a=%0d d=%h want write 2/F", bus_if.avm_chipselect,
                bus_if.avm_address, bus_if.avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (!(wr_en && bus_if.avm_address == 2'd3 && bus_if.avm_writedata == 32'hF)) begin
            errors++; $display("FAIL rstdb_clr got cs=%b a=%0d d=%h want write 3/F", bus_if.avm_chipselect,
                bus_if.avm_address, bus_if.avm_writedata);
        end
        repeat (3) @(negedge clk);
        $display("reset during debounce: re-initialised");
    endtask

    task automatic test_enable_low();
        int busy = 0;
        int start = pub_count;
        bit ok;
        enable = 1'b0;
        pins = 4'd4;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.avm_chipselect !== 1'b0 || bus_if.avm_address !== 2'd0) busy++;
        end
        checks++; if (busy != 0) begin errors++; $display("FAIL en_low_bus got %0d busy cycles want 0", busy); end
        checks++; if (bus_if.zone_valid !== 1'b0) begin errors++; $display("FAIL en_low_valid got %b want 0", bus_if.zone_valid); end
        push_exp(4'd4);
        enable = 1'b1;
        wait_pub(start + 1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_high_pub got 0 want 1"); end
        repeat (5) @(negedge clk);
        $display("enable gating: held while low, served when high");
    endtask

    task automatic test_wrap();
        bit ok;
        logic [3:0] v;
        for (int i = 0; i < 256; i++) begin
            v = (i % 2 == 0) ? 4'hA : 4'h4;
            push_exp(v);
            pins = v;
            wait_pub(pub_count + 1, 40, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL wrap_timeout got none want publish %0d", i);
                break;
            end
            repeat (3) @(negedge clk);
        end
        checks++; if (bus_if.change_cnt !== 8'd1) begin errors++; $display("FAIL wrap_change_cnt got %0d want 1", bus_if.change_cnt); end
        checks++; if (bus_if.zone_sel !== 4'h4) begin errors++; $display("FAIL wrap_zone_sel got %0d want 4", bus_if.zone_sel); end
        $display("wrap: change_cnt now %0d", bus_if.change_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.zone_ready = 1'b1;
        test_reset();
        test_publish_clean();
        test_bounce();
        test_ready_low();
        test_return_same();
        test_reset_debounce();
        test_enable_low();
        test_wrap();
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
